dot_frame_loader: RTL and testbench
===================================

# dot_frame_loader

Streaming front end that drives the 16-element dot-product engine. It accepts an 8-bit byte stream over a valid/ready handshake and assembles each 32-byte frame into operand vectors a (bytes 0–15) and b (bytes 16–31). It pulses the engine's start, waits for its done, and returns the 16-bit result on a valid/ready output channel. It is the initiator end of the engine's start/done protocol and sits between the host DMA stream and the engine.

## Interface
- VEC_LEN, 16, elements per operand vector; the frame is 2*VEC_LEN bytes.
- DATA_W, 8, operand element width.
- ACC_W, 16, result width.
- TIMEOUT_CYCLES, 8192, watchdog limit. Used only with DOT_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid && s_ready.
- s_data  in  DATA_W  input byte.
- s_last  in  1  marks the final byte of a frame.
- a_vec  out  DATA_W x VEC_LEN  unpacked operand array a[0:VEC_LEN-1] to the engine.
- b_vec  out  DATA_W x VEC_LEN  unpacked operand array b[0:VEC_LEN-1] to the engine.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  engine completion level.
- eng_c  in  ACC_W  engine result.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted when m_valid && m_ready.
- m_data  out  ACC_W  captured result.
- busy  out  1  high in every state except LOAD.
- err_len  out  1  one-cycle pulse on a frame-length error.
- err_timeout  out  1  one-cycle pulse on a watchdog expiry; tied to 0 when the timeout feature is compiled out.

## Operation
- The FSM has five states: LOAD, DRAIN, START, WAIT, OUT.
- Reset state is LOAD. Every output resets to 0: s_ready, a_vec, b_vec, eng_start, m_valid, m_data, busy, err_len, err_timeout. The byte counter resets to 0.
- LOAD:
  - s_ready=1.
  - Each accepted byte n (0..31) is written to a[n] for n<16, or to b[n-16] for n≥16.
  - Accepted with s_last=1 at n<31: err_len pulse, counter cleared, stay in LOAD. a_vec and b_vec keep their partial contents.
  - Accepted byte 31 with s_last=1: go to START.
  - Accepted byte 31 with s_last=0: err_len pulse, go to DRAIN.
- DRAIN:
  - s_ready=1; bytes are discarded.
  - The accepted byte with s_last=1 returns the FSM to LOAD with the counter at 0.
- START: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - s_ready=0.
  - Completion is a 0→1 transition of eng_done, registered internally (previous-value flop cleared in START).
  - A done level already high when WAIT is entered does not count. The engine must drop done on start.
  - On completion: m_data<=eng_c, go to OUT.
- OUT:
  - m_valid=1; m_data is held stable until m_valid && m_ready.
  - On the handshake: m_valid<=0 in the next cycle, go to LOAD.
- a_vec and b_vec are stable from START until the next byte is accepted in LOAD.
- Reset mid-operation: everything returns immediately to reset values, including a cleared eng_start. Any partial frame is lost.

## Timing
- s_ready is a registered state decode; there is no combinational path from s_valid.
- Frame-to-start latency: eng_start asserts the cycle after byte 31 is accepted.
- Done-to-result latency: the eng_done rising edge is sampled at edge k; m_valid=1 from edge k+1.
- The minimum frame period is 32 + 1 + engine latency + 2 cycles.
- Simultaneous s_last and length error at byte 31: s_last wins, and the frame is good.

## Configuration
- DOT_LOADER_TIMEOUT_EN defined:
  - A 13-bit cycle counter is cleared in START and incremented in WAIT.
  - Reaching TIMEOUT_CYCLES without completion gives an err_timeout pulse and a return to LOAD.
  - No result is produced; m_data is unchanged.
- DOT_LOADER_TIMEOUT_EN undefined:
  - No counter; WAIT waits indefinitely.
  - err_timeout is constant 0.

## Test plan
- Nominal frame: a=1..16, b all 2, engine model returns the dot product → one eng_start pulse; m_valid with m_data=16'd272.
- Output backpressure: m_ready low for 5 cycles after m_valid → m_data=272 held, s_ready=0 throughout; LOAD re-entered the cycle after the handshake.
- Early s_last on byte 9 → err_len pulse, no eng_start. The following good frame (a all 1, b all 3) gives m_data=48.
- Missing s_last on byte 31, then 4 junk bytes with s_last on the 4th → err_len pulse at byte 31, junk discarded, no eng_start; the next frame processes normally.
- Timeout enabled, engine stub never raises done → err_timeout pulse exactly 8192 cycles after eng_start, no m_valid, FSM back in LOAD.
- Reset asserted in WAIT → all outputs 0 immediately. A late eng_done edge after reset release is ignored (FSM in LOAD, no m_valid).

Source files
------------

// File: rtl/dot_frame_loader_if.sv
// Byte-stream input and result output channels of the dot-product frame loader.
//   s_valid/s_ready/s_data/s_last : input byte stream (host -> loader)
//   m_valid/m_ready/m_data        : result channel    (loader -> host)
// The slave modport is the loader's view; the master modport is the host's view.
interface dot_frame_loader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_data;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dot_frame_loader.sv
// Streaming front end for the 16-element dot-product engine.
// Collects a 2*VEC_LEN byte frame into operand vectors a (first half) and
// b (second half), pulses eng_start, waits for a rising edge of eng_done and
// returns eng_c on the result channel.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            dot_frame_loader_if.slave (byte stream in, result out)
//   a_vec, b_vec   operand arrays to the engine
//   eng_start      one-cycle start pulse to the engine
//   eng_done/eng_c engine completion level and result
//   busy           high in every state except LOAD
//   err_len        one-cycle pulse on a frame-length error
//   err_timeout    one-cycle pulse on watchdog expiry (constant 0 unless
//                  DOT_LOADER_TIMEOUT_EN is defined)
// Build option: define DOT_LOADER_TIMEOUT_EN to enable the WAIT watchdog.
module dot_frame_loader #(
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dot_frame_loader_if.slave     bus,
  output logic [DATA_W-1:0]     a_vec [VEC_LEN],
  output logic [DATA_W-1:0]     b_vec [VEC_LEN],
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [ACC_W-1:0]      eng_c,
  output logic                  busy,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int unsigned FRAME_LEN = 2 * VEC_LEN;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam int unsigned IDX_W     = $clog2(VEC_LEN);
  localparam int unsigned LAST_IDX  = FRAME_LEN - 1;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_DRAIN = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             done_s_q, done_p_q;
  logic             s_acc_c;
  logic             at_last_c;
  logic             done_rise_c;
  logic             timeout_c;
  logic             err_len_d;

  assign s_acc_c     = bus.s_valid && bus.s_ready;
  assign at_last_c   = (byte_cnt_q == CNT_W'(LAST_IDX));
  assign done_rise_c = done_s_q && !done_p_q;

  // Next-state decode and length-error detection.
  always_comb begin
    state_d   = state_q;
    err_len_d = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (s_acc_c) begin
          if (bus.s_last) begin
            // s_last on the final byte wins over any length error
            if (at_last_c) state_d   = S_START;
            else           err_len_d = 1'b1;
          end else if (at_last_c) begin
            err_len_d = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (s_acc_c && bus.s_last) state_d = S_LOAD;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done_rise_c)    state_d = S_OUT;
        else if (timeout_c) state_d = S_LOAD;
      end
      S_OUT: begin
        if (bus.m_valid && bus.m_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State register; control outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      bus.s_ready <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      bus.m_valid <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus.s_ready <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      busy        <= (state_d != S_LOAD);
      eng_start   <= (state_d == S_START);
      bus.m_valid <= (state_d == S_OUT);
      err_len     <= err_len_d;
    end
  end

  // Byte counter and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        a_vec[i] <= '0;
        b_vec[i] <= '0;
      end
    end else if (state_q == S_LOAD && s_acc_c) begin
      // counter wraps to 0 after the last byte, which is the DRAIN entry value
      byte_cnt_q <= bus.s_last ? '0 : byte_cnt_q + CNT_W'(1);
      if (byte_cnt_q[CNT_W-1]) b_vec[byte_cnt_q[IDX_W-1:0]] <= bus.s_data;
      else                     a_vec[byte_cnt_q[IDX_W-1:0]] <= bus.s_data;
    end else if (state_q == S_DRAIN && s_acc_c && bus.s_last) begin
      byte_cnt_q <= '0;
    end
  end

  // Done edge detector: sample flop plus previous-value flop, both cleared in
  // START so only a fresh rise after the engine has dropped done counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_s_q <= 1'b0;
      done_p_q <= 1'b0;
    end else if (state_q == S_START) begin
      done_s_q <= 1'b0;
      done_p_q <= 1'b0;
    end else begin
      done_s_q <= eng_done;
      done_p_q <= done_s_q;
    end
  end

  // Result capture; held until the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_data <= '0;
    end else if (state_q == S_WAIT && done_rise_c) begin
      bus.m_data <= eng_c;
    end
  end

`ifdef DOT_LOADER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = 8192;
  localparam int unsigned WD_W           = 13;

  logic [WD_W-1:0] wd_cnt_q;

  // Expires when eng_start cycle plus elapsed WAIT cycles reaches the limit.
  assign timeout_c = (state_q == S_WAIT) && !done_rise_c &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 2));

  // Watchdog counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q    <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_c;
      if (state_q == S_START)     wd_cnt_q <= '0;
      else if (state_q == S_WAIT) wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`else
  assign timeout_c   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dot_frame_loader.sv
// Directed self-checking bench for dot_frame_loader with a simple engine model.
module tb_dot_frame_loader;

  localparam int ENG_LAT = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_vec [16];
  logic [7:0] b_vec [16];
  logic       eng_start;
  logic       eng_done;
  logic [15:0] eng_c;
  logic       busy;
  logic       err_len;
  logic       err_timeout;

  dot_frame_loader_if bus ();

  dot_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_c       (eng_c),
    .busy        (busy),
    .err_len     (err_len),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;
  int n_start;
  int n_errlen;
  int n_tmo;
  int n_mv;
  int t_start;
  int t_tmo;

  logic       eng_en;
  logic       force_done;
  int         eng_cnt;
  logic [7:0] frame [32];

  // Engine model: drops done on start, raises it ENG_LAT cycles later.
  function automatic logic [15:0] dot_now();
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc + 16'(a_vec[i]) * 16'(b_vec[i]);
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done <= 1'b0;
      eng_c    <= '0;
      eng_cnt  <= 0;
    end else if (force_done) begin
      eng_done <= 1'b1;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      eng_cnt  <= eng_en ? ENG_LAT : 0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_c    <= dot_now();
      end
    end
  end

  // Event monitor, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (eng_start)   begin n_start++; t_start = cyc; end
    if (err_len)     n_errlen++;
    if (err_timeout) begin n_tmo++; t_tmo = cyc; end
    if (bus.m_valid) n_mv++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("s_ready_wait", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_byte(frame[i], (i == last_at));
  endtask

  task automatic wait_mvalid(input string tag);
    int t;
    t = 0;
    while (!bus.m_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(bus.m_valid), 32'd1);
  endtask

  int s0;
  int e0;
  int m0;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    n_start = 0; n_errlen = 0; n_tmo = 0; n_mv = 0;
    t_start = 0; t_tmo = 0;
    eng_en = 1'b1; force_done = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_start",   32'(eng_start),   32'd0);
    check("rst_err_tmo", 32'(err_timeout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("load_s_ready", 32'(bus.s_ready), 32'd1);

    // Nominal frame: a=1..16, b=2 -> 2*136 = 272
    for (int i = 0; i < 16; i++) begin frame[i] = 8'(i + 1); frame[16 + i] = 8'd2; end
    send_frame(32, 31);
    check("start_after_b31", 32'(eng_start), 32'd1);
    check("busy_in_start",   32'(busy),      32'd1);
    check("a15",             32'(a_vec[15]), 32'd16);
    check("b0",              32'(b_vec[0]),  32'd2);
    @(negedge clk);
    check("start_one_cycle", 32'(eng_start), 32'd0);
    wait_mvalid("nominal_mvalid");
    check("nominal_m_data", 32'(bus.m_data), 32'd272);
    @(negedge clk);
    check("nominal_mvalid_drop", 32'(bus.m_valid), 32'd0);
    check("nominal_back_load",   32'(bus.s_ready), 32'd1);
    #2;
    check("nominal_start_cnt", 32'(n_start), 32'd1);

    // Output backpressure
    bus.m_ready = 1'b0;
    send_frame(32, 31);
    wait_mvalid("bp_mvalid");
    for (int k = 0; k < 5; k++) begin
      check("bp_m_data",  32'(bus.m_data),  32'd272);
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    check("bp_mvalid_held", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("bp_mvalid_drop", 32'(bus.m_valid), 32'd0);
    check("bp_s_ready_up",  32'(bus.s_ready), 32'd1);
    check("bp_busy_low",    32'(busy),        32'd0);

    // Early s_last on byte 9, then a=1s b=3s -> 48
    #2; s0 = n_start; e0 = n_errlen;
    @(negedge clk);
    for (int i = 0; i < 32; i++) frame[i] = 8'(8'h40 + i);
    send_frame(10, 9);
    check("early_err_len", 32'(err_len),  32'd1);
    check("early_busy",    32'(busy),     32'd0);
    check("early_partial", 32'(a_vec[9]), 32'h49);
    repeat (4) @(negedge clk);
    #2;
    check("early_no_start", 32'(n_start),  32'(s0));
    check("early_err_cnt",  32'(n_errlen), 32'(e0 + 1));
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin frame[i] = 8'd1; frame[16 + i] = 8'd3; end
    send_frame(32, 31);
    wait_mvalid("early_next_mvalid");
    check("early_next_m_data", 32'(bus.m_data), 32'd48);
    @(negedge clk);

    // Missing s_last on byte 31, then 4 junk bytes
    #2; s0 = n_start; e0 = n_errlen;
    @(negedge clk);
    for (int i = 0; i < 32; i++) frame[i] = 8'h55;
    send_frame(32, -1);
    check("nolast_err_len", 32'(err_len),     32'd1);
    check("drain_busy",     32'(busy),        32'd1);
    check("drain_s_ready",  32'(bus.s_ready), 32'd1);
    for (int j = 0; j < 4; j++) send_byte(8'hEE, (j == 3));
    check("drain_exit_busy", 32'(busy),     32'd0);
    check("drain_discard",   32'(a_vec[0]), 32'h55);
    #2;
    check("drain_no_start", 32'(n_start),  32'(s0));
    check("drain_err_cnt",  32'(n_errlen), 32'(e0 + 1));
    @(negedge clk);
    // a=b=1..16 -> sum of squares = 1496
    for (int i = 0; i < 16; i++) begin frame[i] = 8'(i + 1); frame[16 + i] = 8'(i + 1); end
    send_frame(32, 31);
    wait_mvalid("drain_next_mvalid");
    check("drain_next_m_data", 32'(bus.m_data), 32'd1496);
    @(negedge clk);

`ifdef DOT_LOADER_TIMEOUT_EN
    // Engine never answers: watchdog fires 8192 cycles after eng_start
    eng_en = 1'b0;
    #2; m0 = n_mv;
    @(negedge clk);
    send_frame(32, 31);
    begin
      int t;
      t = 0;
      while (!err_timeout && t < 9000) begin
        @(negedge clk);
        t++;
      end
    end
    check("tmo_pulse",   32'(err_timeout), 32'd1);
    check("tmo_busy",    32'(busy),        32'd0);
    check("tmo_s_ready", 32'(bus.s_ready), 32'd1);
    check("tmo_m_data",  32'(bus.m_data),  32'd1496);
    #2;
    check("tmo_latency", 32'(t_tmo - t_start), 32'd8192);
    check("tmo_no_mv",   32'(n_mv),            32'(m0));
    @(negedge clk);
    check("tmo_one_cycle", 32'(err_timeout), 32'd0);
`endif

    // Reset asserted in WAIT, then a late done edge
    eng_en = 1'b0;
    send_frame(32, 31);
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",    32'(busy),        32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("mid_rst_m_data",  32'(bus.m_data),  32'd0);
    check("mid_rst_start",   32'(eng_start),   32'd0);
    check("mid_rst_a0",      32'(a_vec[0]),    32'd0);
    check("mid_rst_b15",     32'(b_vec[15]),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2; m0 = n_mv;
    @(negedge clk);
    force_done = 1'b1;
    repeat (10) @(negedge clk);
    check("late_done_busy",    32'(busy),        32'd0);
    check("late_done_mvalid",  32'(bus.m_valid), 32'd0);
    check("late_done_s_ready", 32'(bus.s_ready), 32'd1);
    #2;
    check("late_done_no_mv",   32'(n_mv),        32'(m0));
`ifndef DOT_LOADER_TIMEOUT_EN
    check("no_tmo_pulses", 32'(n_tmo), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
